// File: rtl/tetris_field_if.sv
// Command/response/display bundle for the tetris_field playfield engine.
// TETRIS_FIELD_GARBAGE_EN adds the garbage_row input used by cmd_op=11.
interface tetris_field_if #(
    parameter int unsigned COLS       = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned PIECE_ROWS = 4,
    parameter int unsigned SCORE_W    = 16,
    parameter int unsigned RW         = $clog2(ROWS) + 1
);
    logic                       cmd_valid;
    logic [1:0]                 cmd_op;
    logic                       cmd_ready;
    logic [RW-1:0]              piece_row;
    logic [PIECE_ROWS*COLS-1:0] piece_mask;
    logic                       rsp_valid;
    logic                       rsp_collide;
    logic [2:0]                 lines_cleared;
    logic [SCORE_W-1:0]         score;
    logic                       game_over;
    logic [RW-1:0]              rd_row;
    logic [COLS-1:0]            rd_data;
`ifdef TETRIS_FIELD_GARBAGE_EN
    logic [COLS-1:0]            garbage_row;

    modport master (
        output cmd_valid, cmd_op, piece_row, piece_mask, rd_row, garbage_row,
        input  cmd_ready, rsp_valid, rsp_collide, lines_cleared, score, game_over, rd_data
    );
    modport slave (
        input  cmd_valid, cmd_op, piece_row, piece_mask, rd_row, garbage_row,
        output cmd_ready, rsp_valid, rsp_collide, lines_cleared, score, game_over, rd_data
    );
`else
    modport master (
        output cmd_valid, cmd_op, piece_row, piece_mask, rd_row,
        input  cmd_ready, rsp_valid, rsp_collide, lines_cleared, score, game_over, rd_data
    );
    modport slave (
        input  cmd_valid, cmd_op, piece_row, piece_mask, rd_row,
        output cmd_ready, rsp_valid, rsp_collide, lines_cleared, score, game_over, rd_data
    );
`endif
endinterface

// File: rtl/tetris_field.sv
// Tetris playfield engine: locked-cell board, collision check, lock with
// sequential row-clear scan, saturating score, sticky top-out, display read port.
// Optional macro TETRIS_FIELD_GARBAGE_EN turns cmd_op=11 into a garbage-row push;
// without it cmd_op=11 is a one-cycle NOP.
module tetris_field #(
    parameter int unsigned COLS       = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned PIECE_ROWS = 4,
    parameter int unsigned SCORE_W    = 16,
    parameter int unsigned RW         = $clog2(ROWS) + 1
) (
    input logic           CLK,
    input logic           CLR,
    tetris_field_if.slave fld
);
    localparam int unsigned IW = RW + 2;
    localparam int unsigned MW = PIECE_ROWS * COLS;
    localparam int unsigned SW = SCORE_W + 6;

    typedef enum logic [2:0] {IDLE, CHECK, MERGE, SCAN, WIPE, DONE, OPT} state_t;

    state_t          state;
    logic [COLS-1:0] board [ROWS];
    logic [RW-1:0]   pr_q;
    logic [MW-1:0]   mask_q;
    logic [RW-1:0]   sc;
    logic [2:0]      cnt;
`ifdef TETRIS_FIELD_GARBAGE_EN
    logic [COLS-1:0] garb_q;
`endif

    logic [COLS-1:0] foot_c [ROWS];
    logic            floor_c;
    logic            collide_c;
    logic [COLS-1:0] rd_c;
    logic [COLS-1:0] scan_row_c;
    logic            scan_full_c;
    logic [5:0]      pts_c;
    logic [SW-1:0]   sum_c;

    // Piece footprint per board row, floor hit and overlap with locked cells
    always_comb begin
        floor_c   = 1'b0;
        collide_c = 1'b0;
        for (int i = 0; i < ROWS; i++) foot_c[i] = '0;
        for (int r = 0; r < PIECE_ROWS; r++) begin
            if ((mask_q[r*COLS +: COLS] != '0) && ((IW'(pr_q) + IW'(r)) >= IW'(ROWS)))
                floor_c = 1'b1;
            for (int i = 0; i < ROWS; i++) begin
                if ((IW'(pr_q) + IW'(r)) == IW'(i))
                    foot_c[i] = foot_c[i] | mask_q[r*COLS +: COLS];
            end
        end
        for (int i = 0; i < ROWS; i++) begin
            if ((board[i] & foot_c[i]) != '0) collide_c = 1'b1;
        end
        collide_c = collide_c | floor_c;
    end

    // Row muxes for the display port and the scan pointer; off-board reads give 0
    always_comb begin
        rd_c       = '0;
        scan_row_c = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (fld.rd_row == RW'(i)) rd_c = board[i];
            if (sc == RW'(i)) scan_row_c = board[i];
        end
        scan_full_c = (scan_row_c == '1);
    end

    // Triangular line bonus and widened score sum for saturation
    always_comb begin
        pts_c = 6'((6'(cnt) * (6'(cnt) + 6'd1)) >> 1);
        sum_c = SW'(fld.score) + SW'(pts_c);
    end

    // Control FSM, board storage and all registered outputs
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state             <= IDLE;
            for (int i = 0; i < ROWS; i++) board[i] <= '0;
            pr_q              <= '0;
            mask_q            <= '0;
            sc                <= '0;
            cnt               <= '0;
            fld.cmd_ready     <= 1'b1;
            fld.rsp_valid     <= 1'b0;
            fld.rsp_collide   <= 1'b0;
            fld.lines_cleared <= '0;
            fld.score         <= '0;
            fld.game_over     <= 1'b0;
            fld.rd_data       <= '0;
`ifdef TETRIS_FIELD_GARBAGE_EN
            garb_q            <= '0;
`endif
        end else begin
            fld.rd_data   <= rd_c;
            fld.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fld.cmd_valid && fld.cmd_ready) begin
                        pr_q          <= fld.piece_row;
                        mask_q        <= fld.piece_mask;
                        fld.cmd_ready <= 1'b0;
`ifdef TETRIS_FIELD_GARBAGE_EN
                        garb_q        <= fld.garbage_row;
`endif
                        case (fld.cmd_op)
                            2'b00:   state <= CHECK;
                            2'b01:   state <= MERGE;
                            2'b10:   state <= WIPE;
                            default: state <= OPT;
                        endcase
                    end else begin
                        // ready returns the cycle after a response pulse
                        fld.cmd_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    fld.rsp_collide <= collide_c | fld.game_over;
                    fld.rsp_valid   <= 1'b1;
                    state           <= IDLE;
                end
                MERGE: begin
                    if (!fld.game_over) begin
                        for (int i = 0; i < ROWS; i++) board[i] <= board[i] | foot_c[i];
                    end
                    sc    <= RW'(ROWS - 1);
                    cnt   <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    // a full row collapses and the same index is re-examined
                    if (scan_full_c) begin
                        for (int i = 1; i < ROWS; i++) begin
                            if (RW'(i) <= sc) board[i] <= board[i-1];
                        end
                        board[0] <= '0;
                        cnt      <= cnt + 3'd1;
                    end else if (sc == '0) begin
                        state <= DONE;
                    end else begin
                        sc <= sc - RW'(1);
                    end
                end
                DONE: begin
                    fld.rsp_valid <= 1'b1;
                    if (fld.game_over) begin
                        fld.lines_cleared <= '0;
                    end else begin
                        fld.lines_cleared <= cnt;
                        fld.score <= (sum_c[SW-1:SCORE_W] != '0) ? '1 : sum_c[SCORE_W-1:0];
                    end
                    if (board[0] != '0) fld.game_over <= 1'b1;
                    state <= IDLE;
                end
                WIPE: begin
                    for (int i = 0; i < ROWS; i++) board[i] <= '0;
                    fld.score         <= '0;
                    fld.game_over     <= 1'b0;
                    fld.lines_cleared <= '0;
                    fld.rsp_valid     <= 1'b1;
                    state             <= IDLE;
                end
                OPT: begin
`ifdef TETRIS_FIELD_GARBAGE_EN
                    if (board[0] != '0) fld.game_over <= 1'b1;
                    for (int i = 0; i < ROWS - 1; i++) board[i] <= board[i+1];
                    board[ROWS-1] <= garb_q;
`endif
                    fld.rsp_valid <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tetris_field.sv
// Scoreboard bench for tetris_field: driver updates a row-list model and queues
// expected responses; a negedge monitor pops and compares on every rsp_valid.
module tb_tetris_field;
    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int PR   = 4;
    localparam int SW   = 5;
    localparam int RW   = $clog2(ROWS) + 1;
    localparam int SMAX = (1 << SW) - 1;

    typedef struct {
        int acc;
        int lat;
        int col;
        int lines;
        int score;
        int go;
        int rd;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rdy_chk = 1'b0;
    bit   abort = 1'b0;
    exp_t q[$];
    exp_t me;

    int mb[ROWS];
    int mscore, mgo, mcol, mlines;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tetris_field_if #(.COLS(COLS), .ROWS(ROWS), .PIECE_ROWS(PR), .SCORE_W(SW), .RW(RW)) f();

    tetris_field #(.COLS(COLS), .ROWS(ROWS), .PIECE_ROWS(PR), .SCORE_W(SW), .RW(RW)) dut (
        .CLK(clk),
        .CLR(clr),
        .fld(f)
    );

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ROWS; i++) mb[i] = 0;
        mscore = 0; mgo = 0; mcol = 0; mlines = 0;
    endtask

    // Reference model: rows as a list, full rows removed and zeros fed in on top
    task automatic model_cmd(input int op, input int pr, input logic [31:0] mask,
                             input int rr, output exp_t e);
        int m, idx, c, k, j, pre_rd;
        int nb[ROWS];
        pre_rd = (rr < ROWS) ? mb[rr] : 0;
        e.lat = 1;
        case (op)
            0: begin
                c = mgo;
                for (int r = 0; r < PR; r++) begin
                    m = int'(mask[r*COLS +: COLS]);
                    idx = pr + r;
                    if (m != 0 && idx >= ROWS) c = 1;
                    if (idx < ROWS && (mb[idx] & m) != 0) c = 1;
                end
                mcol = c;
            end
            1: begin
                if (mgo == 0) begin
                    for (int r = 0; r < PR; r++) begin
                        idx = pr + r;
                        if (idx < ROWS) mb[idx] = mb[idx] | int'(mask[r*COLS +: COLS]);
                    end
                end
                k = 0;
                j = ROWS - 1;
                for (int i = 0; i < ROWS; i++) nb[i] = 0;
                for (int i = ROWS - 1; i >= 0; i--) begin
                    if (mb[i] == 255) k++;
                    else begin nb[j] = mb[i]; j--; end
                end
                for (int i = 0; i < ROWS; i++) mb[i] = nb[i];
                e.lat = 2 + ROWS + k;
                if (mgo != 0) mlines = 0;
                else begin
                    mlines = k;
                    mscore = mscore + k * (k + 1) / 2;
                    if (mscore > SMAX) mscore = SMAX;
                end
                if (mb[0] != 0) mgo = 1;
            end
            2: begin
                for (int i = 0; i < ROWS; i++) mb[i] = 0;
                mscore = 0; mgo = 0; mlines = 0;
            end
            default: ;
        endcase
        e.col = mcol; e.lines = mlines; e.score = mscore; e.go = mgo;
        e.rd = (op == 2) ? pre_rd : ((rr < ROWS) ? mb[rr] : 0);
        e.acc = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (f.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (f.cmd_ready !== 1'b1) begin
            checks++; failures++; abort = 1'b1;
            $display("FAIL ready_timeout actual=%b expected=1", f.cmd_ready);
        end
    endtask

    task automatic issue(input int op, input int pr, input logic [31:0] mask);
        exp_t e;
        int rr;
        if (abort) return;
        wait_ready();
        if (abort) return;
        rr = $urandom_range(0, ROWS + 1);
        f.cmd_valid = 1'b1; f.cmd_op = 2'(op); f.piece_row = RW'(pr);
        f.piece_mask = mask; f.rd_row = RW'(rr);
        model_cmd(op, pr, mask, rr, e);
        @(posedge clk); #1;
        e.acc = cyc;
        q.push_back(e);
        f.cmd_valid = 1'b0;
        f.cmd_op = 2'($urandom); f.piece_row = RW'($urandom); f.piece_mask = $urandom;
    endtask

    task automatic sweep(input string nm);
        if (abort) return;
        wait_ready();
        for (int i = 0; i <= ROWS; i++) begin
            f.rd_row = RW'(i + (i == ROWS ? 1 : 0));
            @(negedge clk);
            chk(nm, int'(f.rd_data), (i < ROWS) ? mb[i] : 0);
        end
    endtask

    // Monitor: one pop per response pulse, plus ready handshake around it
    always @(negedge clk) begin
        if (clr) rdy_chk = 1'b0;
        else begin
            if (rdy_chk) begin chk("ready_after_rsp", int'(f.cmd_ready), 1); rdy_chk = 1'b0; end
            if (f.rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp_valid actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    me = q.pop_front();
                    chk("latency", cyc - me.acc, me.lat);
                    chk("rsp_collide", int'(f.rsp_collide), me.col);
                    chk("lines_cleared", int'(f.lines_cleared), me.lines);
                    chk("score", int'(f.score), me.score);
                    chk("game_over", int'(f.game_over), me.go);
                    chk("rd_data", int'(f.rd_data), me.rd);
                    chk("ready_during_rsp", int'(f.cmd_ready), 0);
                    rdy_chk = 1'b1;
                end
            end
        end
    end

    task automatic reset_checks(input string nm);
        chk({nm, "_ready"}, int'(f.cmd_ready), 1);
        chk({nm, "_rsp_valid"}, int'(f.rsp_valid), 0);
        chk({nm, "_collide"}, int'(f.rsp_collide), 0);
        chk({nm, "_lines"}, int'(f.lines_cleared), 0);
        chk({nm, "_score"}, int'(f.score), 0);
        chk({nm, "_game_over"}, int'(f.game_over), 0);
        chk({nm, "_rd_data"}, int'(f.rd_data), 0);
    endtask

    initial begin
        int op, pr, sel, idx, n;
        logic [31:0] mask;
        f.cmd_valid = 1'b0; f.cmd_op = '0; f.piece_row = '0; f.piece_mask = '0; f.rd_row = '0;
`ifdef TETRIS_FIELD_GARBAGE_EN
        f.garbage_row = '0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks("reset");
        clr = 1'b0;
        sweep("reset_board");

        // Directed scenarios
        issue(0, 4, 32'h0000_00F0);
        issue(0, 7, 32'h0000_C000);
        issue(1, 6, 32'h0000_00FE);
        issue(1, 7, 32'h0000_00FE);
        issue(1, 5, 32'h0001_0100);
        sweep("two_line_board");

        issue(2, 0, 32'h0);
        for (int t = 0; t < 5; t++) begin
            issue(1, 4, 32'hFEFE_FEFE);
            issue(1, 4, 32'h0101_0101);
        end
        sweep("tetris_board");

        issue(1, 0, 32'h0000_0001);
        issue(0, 4, 32'h0);
        issue(1, 3, 32'h0000_00FF);
        sweep("topout_board");
        issue(2, 0, 32'h0);
        sweep("wipe_board");

        // Abort a scan with CLR
        issue(1, 2, 32'h0000_000F);
        repeat (4) @(negedge clk);
        #2 clr = 1'b1;
        #1 reset_checks("abort");
        q.delete();
        model_reset();
        @(negedge clk); #2 clr = 1'b0;
        repeat (20) @(negedge clk);
        sweep("abort_board");

        // Randomized traffic
        for (int t = 0; t < 250 && !abort; t++) begin
            sel = $urandom_range(0, 99);
            if (mgo != 0 && $urandom_range(0, 2) == 0) op = 2;
            else if (sel < 35) op = 0;
            else if (sel < 87) op = 1;
            else if (sel < 94) op = 2;
`ifdef TETRIS_FIELD_GARBAGE_EN
            else op = 0;
`else
            else op = 3;
`endif
            pr = ($urandom_range(0, 9) < 8) ? $urandom_range(2, ROWS + 1) : $urandom_range(0, (1 << RW) - 1);
            mask = '0;
            for (int r = 0; r < PR; r++) begin
                idx = pr + r;
                n = $urandom_range(0, 9);
                if (n < 3 && idx < ROWS) mask[r*COLS +: COLS] = 8'(~mb[idx]);
                else if (n < 6) mask[r*COLS +: COLS] = 8'($urandom & $urandom);
            end
            issue(op, pr, mask);
        end
        sweep("final_board");

        n = 0;
        while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL pending_responses actual=%0d expected=0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
